// File: rtl/lsu_mem_stage.sv
// Registered memory-access stage: load FSM to the memory controller plus a posted store buffer.
// Optional store-to-load forwarding from the buffer is enabled by defining LSU_ST2LD_FWD_EN.
module lsu_mem_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [2:0]        funct3_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [XLEN-1:0]   store_data_in,
  input  logic [4:0]        rd_addr_in,
  input  logic [XLEN-1:0]   rd_data_in,
  input  logic              rd_we_in,
  output logic [4:0]        rd_addr_out,
  output logic [XLEN-1:0]   rd_data_out,
  output logic              rd_we_out,
  output logic              fwd_en_out,
  output logic [4:0]        fwd_addr_out,
  output logic [XLEN-1:0]   fwd_data_out,
  output logic              stall_out,
  output logic              sb_empty_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [XLEN-1:0]   mem_wdata_out,
  output logic [2:0]        mem_len_out,
  input  logic              mem_busy_in,
  input  logic              mem_done_in,
  input  logic [XLEN-1:0]   mem_rdata_in
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StLdReq, StLdWait, StStReq, StStWait} state_e;

  function automatic logic [2:0] len_of(input logic [1:0] sz);
    case (sz)
      2'b00:   len_of = 3'd1;
      2'b01:   len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  // Data is right-aligned; funct3[2] selects zero-extension.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   load_ext = {{(XLEN-8){d[7] & ~f3[2]}}, d[7:0]};
      2'b01:   load_ext = {{(XLEN-16){d[15] & ~f3[2]}}, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [2:0]        ld_len_q, ld_len_d;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [ADDR_W-1:0] sb_addr_d [SB_DEPTH];
  logic [XLEN-1:0]   sb_data_q [SB_DEPTH];
  logic [XLEN-1:0]   sb_data_d [SB_DEPTH];
  logic [2:0]        sb_len_q  [SB_DEPTH];
  logic [2:0]        sb_len_d  [SB_DEPTH];
  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic              rd_we_q, rd_we_d;

  logic            is_load, is_store, full, push, pop, ld_done, conflict, fwd_hit, ld_issue;
  logic [2:0]      ld_len;
  logic [XLEN-1:0] fwd_data;
`ifdef LSU_ST2LD_FWD_EN
  logic [PtrW-1:0] young;
`endif

  always_comb begin
    is_load  = valid_in & is_load_in;
    is_store = valid_in & is_store_in;
    ld_len   = len_of(funct3_in[1:0]);
    full     = (count_q == CntW'(SB_DEPTH));
    pop      = (state_q == StStWait) & mem_done_in;
    ld_done  = (state_q == StLdWait) & mem_done_in;
    push     = is_store & (~full | pop);
    conflict = 1'b0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
`ifdef LSU_ST2LD_FWD_EN
    young    = head_q;
`endif
    // Walk oldest to youngest so the last match is the youngest entry.
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      if ((CntW'(k) < count_q) &&
          (sb_addr_q[head_q + PtrW'(k)][ADDR_W-1:2] == mem_addr_in[ADDR_W-1:2])) begin
        conflict = 1'b1;
`ifdef LSU_ST2LD_FWD_EN
        young    = head_q + PtrW'(k);
`endif
      end
    end
`ifdef LSU_ST2LD_FWD_EN
    fwd_hit  = is_load & conflict & (sb_addr_q[young] == mem_addr_in) &
               (sb_len_q[young] >= ld_len);
    fwd_data = load_ext(sb_data_q[young], funct3_in);
`endif
    ld_issue  = is_load & ~conflict & (state_q == StIdle);
    stall_out = (is_load & ~(ld_done | fwd_hit)) | (is_store & full & ~pop);

    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_len_d  = ld_len_q;
    unique case (state_q)
      StIdle: begin
        if (ld_issue) begin
          state_d   = StLdReq;
          ld_addr_d = mem_addr_in;
          ld_len_d  = ld_len;
        end else if (count_q != '0) begin
          state_d = StStReq;
        end
      end
      StLdReq:  if (!mem_busy_in) state_d = StLdWait;
      StLdWait: if (mem_done_in) state_d = StIdle;
      StStReq:  if (!mem_busy_in) state_d = StStWait;
      StStWait: if (mem_done_in) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    sb_addr_d = sb_addr_q;
    sb_data_d = sb_data_q;
    sb_len_d  = sb_len_q;
    if (push) begin
      sb_addr_d[tail_q] = mem_addr_in;
      sb_data_d[tail_q] = store_data_in;
      sb_len_d[tail_q]  = ld_len;
    end
    tail_d  = tail_q + PtrW'(push);
    head_d  = head_q + PtrW'(pop);
    count_d = count_q + CntW'(push) - CntW'(pop);

    rd_addr_d = rd_addr_in;
    rd_data_d = rd_data_in;
    rd_we_d   = valid_in & rd_we_in;
    if (stall_out) begin
      rd_addr_d = '0;
      rd_data_d = '0;
      rd_we_d   = 1'b0;
    end else if (is_load) begin
      rd_data_d = fwd_hit ? fwd_data : load_ext(mem_rdata_in, funct3_in);
      rd_we_d   = rd_we_in;
    end else if (is_store) begin
      rd_we_d = 1'b0;
    end

    mem_req_out   = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    mem_len_out   = '0;
    if (state_q == StLdReq) begin
      mem_req_out  = 1'b1;
      mem_addr_out = ld_addr_q;
      mem_len_out  = ld_len_q;
    end else if (state_q == StStReq) begin
      mem_req_out   = 1'b1;
      mem_we_out    = 1'b1;
      mem_addr_out  = sb_addr_q[head_q];
      mem_wdata_out = sb_data_q[head_q];
      mem_len_out   = sb_len_q[head_q];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      ld_addr_q <= '0;
      ld_len_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      for (int unsigned i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
        sb_len_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_len_q  <= ld_len_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_we_q   <= rd_we_d;
      sb_addr_q <= sb_addr_d;
      sb_data_q <= sb_data_d;
      sb_len_q  <= sb_len_d;
    end
  end

  assign rd_addr_out  = rd_addr_q;
  assign rd_data_out  = rd_data_q;
  assign rd_we_out    = rd_we_q;
  assign fwd_en_out   = rd_we_q;
  assign fwd_addr_out = rd_addr_q;
  assign fwd_data_out = rd_data_q;
  assign sb_empty_out = (count_q == '0);

endmodule
